// File: rtl/arbitro_mem_dados.sv
// Data-memory arbiter: shares the single-port bancoMem between the nRisc core (port 0)
// and the loader/debug master (port 1), core first with a bounded wait for port 1.
module arbitro_mem_dados #(
  parameter int unsigned LARG_DADO    = 8,
  parameter int unsigned LARG_END     = 8,
  parameter int unsigned LAT_LEITURA  = 1,
  parameter int unsigned MAX_SEGUIDOS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_ler_i,
  input  logic                 req0_escreve_i,
  input  logic [LARG_END-1:0]  req0_end_i,
  input  logic [LARG_DADO-1:0] req0_dado_i,
  output logic                 ack0_o,
  output logic [LARG_DADO-1:0] dado_lido0_o,
  output logic                 espera0_c_o,
  input  logic                 req1_ler_i,
  input  logic                 req1_escreve_i,
  input  logic [LARG_END-1:0]  req1_end_i,
  input  logic [LARG_DADO-1:0] req1_dado_i,
  output logic                 ack1_o,
  output logic [LARG_DADO-1:0] dado_lido1_o,
  output logic                 mem_ler_o,
  output logic                 mem_escreve_o,
  output logic [LARG_END-1:0]  mem_end_o,
  output logic [LARG_DADO-1:0] mem_dado_o,
  input  logic [LARG_DADO-1:0] mem_dado_lido_i
);

  localparam int unsigned LAT_W = (LAT_LEITURA > 1) ? $clog2(LAT_LEITURA) : 1;
  localparam int unsigned SEG_W = $clog2(MAX_SEGUIDOS + 1);

  typedef enum logic [1:0] {OCIOSO, ESCRITA, LEITURA, ENTREGA} estado_t;

  estado_t              estado_q, estado_d;
  logic                 id_q, id_d;
  logic [LARG_END-1:0]  end_q, end_d;
  logic [LARG_DADO-1:0] dado_q, dado_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [LARG_DADO-1:0] lido0_q, lido0_d;
  logic [LARG_DADO-1:0] lido1_q, lido1_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 mem_ler_q, mem_ler_d;
  logic                 mem_escreve_q, mem_escreve_d;

  logic req0, req1, prio1;

  assign req0  = req0_ler_i | req0_escreve_i;
  assign req1  = req1_ler_i | req1_escreve_i;
  assign prio1 = req1 && (seg_q == SEG_W'(MAX_SEGUIDOS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q      <= OCIOSO;
      id_q          <= 1'b0;
      end_q         <= '0;
      dado_q        <= '0;
      lat_q         <= '0;
      seg_q         <= '0;
      lido0_q       <= '0;
      lido1_q       <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      mem_ler_q     <= 1'b0;
      mem_escreve_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      id_q          <= id_d;
      end_q         <= end_d;
      dado_q        <= dado_d;
      lat_q         <= lat_d;
      seg_q         <= seg_d;
      lido0_q       <= lido0_d;
      lido1_q       <= lido1_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      mem_ler_q     <= mem_ler_d;
      mem_escreve_q <= mem_escreve_d;
    end
  end

  // Grant, latch and sequence one transaction; outputs follow the next state so they
  // are registered yet valid in the same cycle as the state they belong to.
  always_comb begin
    estado_d = estado_q;
    id_d     = id_q;
    end_d    = end_q;
    dado_d   = dado_q;
    lat_d    = lat_q;
    seg_d    = seg_q;
    lido0_d  = lido0_q;
    lido1_d  = lido1_q;

    unique case (estado_q)
      OCIOSO: begin
        lat_d = '0;
        if (!req1) seg_d = '0;
        if (req0 && !prio1) begin
          id_d     = 1'b0;
          end_d    = req0_end_i;
          dado_d   = req0_dado_i;
          estado_d = req0_escreve_i ? ESCRITA : LEITURA;
          if (req1 && (seg_q != SEG_W'(MAX_SEGUIDOS))) seg_d = seg_q + SEG_W'(1);
        end else if (req1) begin
          id_d     = 1'b1;
          end_d    = req1_end_i;
          dado_d   = req1_dado_i;
          estado_d = req1_escreve_i ? ESCRITA : LEITURA;
          seg_d    = '0;
        end
      end
      ESCRITA: estado_d = OCIOSO;
      LEITURA: begin
        if (lat_q == LAT_W'(LAT_LEITURA - 1)) begin
          estado_d = ENTREGA;
          if (id_q) lido1_d = mem_dado_lido_i;
          else      lido0_d = mem_dado_lido_i;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ENTREGA: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase

    mem_escreve_d = (estado_d == ESCRITA);
    mem_ler_d     = (estado_d == LEITURA);
    ack0_d        = ((estado_d == ESCRITA) || (estado_d == ENTREGA)) && !id_d;
    ack1_d        = ((estado_d == ESCRITA) || (estado_d == ENTREGA)) && id_d;
  end

  assign ack0_o        = ack0_q;
  assign ack1_o        = ack1_q;
  assign dado_lido0_o  = lido0_q;
  assign dado_lido1_o  = lido1_q;
  assign mem_ler_o     = mem_ler_q;
  assign mem_escreve_o = mem_escreve_q;
  assign mem_end_o     = end_q;
  assign mem_dado_o    = dado_q;
  assign espera0_c_o   = req0 & ~ack0_q;

endmodule

// File: tb/tb_arbitro_mem_dados.sv
// Bench for arbitro_mem_dados: per-cycle vector table plus starvation and reset sequences.
module tb_arbitro_mem_dados;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_ler, req0_escreve, req1_ler, req1_escreve;
  logic [7:0] req0_end, req0_dado, req1_end, req1_dado;
  logic       ack0, ack1, espera0, mem_ler, mem_escreve;
  logic [7:0] dado_lido0, dado_lido1, mem_end, mem_dado, mem_dado_lido;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  arbitro_mem_dados #(
    .LARG_DADO(8), .LARG_END(8), .LAT_LEITURA(1), .MAX_SEGUIDOS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_ler_i(req0_ler), .req0_escreve_i(req0_escreve),
    .req0_end_i(req0_end), .req0_dado_i(req0_dado),
    .ack0_o(ack0), .dado_lido0_o(dado_lido0), .espera0_c_o(espera0),
    .req1_ler_i(req1_ler), .req1_escreve_i(req1_escreve),
    .req1_end_i(req1_end), .req1_dado_i(req1_dado),
    .ack1_o(ack1), .dado_lido1_o(dado_lido1),
    .mem_ler_o(mem_ler), .mem_escreve_o(mem_escreve),
    .mem_end_o(mem_end), .mem_dado_o(mem_dado),
    .mem_dado_lido_i(mem_dado_lido)
  );

  // Memory model: asynchronous read, write on the edge that ends a mem_escreve cycle.
  initial foreach (mem[i]) mem[i] = 8'h00;
  always @(posedge clk) if (mem_escreve) mem[mem_end] <= mem_dado;
  assign mem_dado_lido = mem[mem_end];

  typedef struct packed {
    logic       ml;
    logic       me;
    logic [7:0] mend;
    logic [7:0] md;
    logic       a0;
    logic       a1;
    logic [7:0] dl0;
    logic [7:0] dl1;
    logic       esp0;
  } out_t;

  typedef struct packed {
    logic [3:0] rq;  // {req0_ler, req0_escreve, req1_ler, req1_escreve}
    logic [7:0] e0, d0, e1, d1;
    out_t       exp;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mkv(input logic [3:0] rq, input logic [7:0] e0, d0, e1, d1,
                               input logic ml, me, input logic [7:0] mend, md,
                               input logic a0, a1, input logic [7:0] dl0, dl1,
                               input logic esp);
    vec_t v;
    v.rq = rq; v.e0 = e0; v.d0 = d0; v.e1 = e1; v.d1 = d1;
    v.exp = '{ml: ml, me: me, mend: mend, md: md, a0: a0, a1: a1,
              dl0: dl0, dl1: dl1, esp0: esp};
    return v;
  endfunction

  function automatic out_t cur();
    out_t o;
    o = '{ml: mem_ler, me: mem_escreve, mend: mem_end, md: mem_dado, a0: ack0, a1: ack1,
          dl0: dado_lido0, dl1: dado_lido1, esp0: espera0};
    return o;
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got ml=%b me=%b end=%h dado=%h a0=%b a1=%b dl0=%h dl1=%h esp0=%b, expected ml=%b me=%b end=%h dado=%h a0=%b a1=%b dl0=%h dl1=%h esp0=%b",
               name, got.ml, got.me, got.mend, got.md, got.a0, got.a1, got.dl0, got.dl1, got.esp0,
               exp.ml, exp.me, exp.mend, exp.md, exp.a0, exp.a1, exp.dl0, exp.dl1, exp.esp0);
    end
  endtask

  task automatic check_v(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n_acks;
    int         viol;
    logic [5:0] ordem;

    rst_n = 1'b0;
    {req0_ler, req0_escreve, req1_ler, req1_escreve} = 4'b0000;
    req0_end = '0; req0_dado = '0; req1_end = '0; req1_dado = '0;

    //                rq       e0     d0     e1     d1     ml  me  mend   md     a0  a1  dl0    dl1    esp
    vecs[0]  = mkv(4'b0100, 8'h05, 8'hA5, 8'h00, 8'h00, 0, 1, 8'h05, 8'hA5, 1, 0, 8'h00, 8'h00, 0);
    vecs[1]  = mkv(4'b0010, 8'h00, 8'h00, 8'h05, 8'h00, 0, 0, 8'h05, 8'hA5, 0, 0, 8'h00, 8'h00, 0);
    vecs[2]  = mkv(4'b0010, 8'h00, 8'h00, 8'h05, 8'h00, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    vecs[3]  = mkv(4'b0010, 8'h00, 8'h00, 8'h05, 8'h00, 0, 0, 8'h05, 8'h00, 0, 1, 8'h00, 8'hA5, 0);
    vecs[4]  = mkv(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'hA5, 0);
    vecs[5]  = mkv(4'b0110, 8'h20, 8'h11, 8'h20, 8'h00, 0, 1, 8'h20, 8'h11, 1, 0, 8'h00, 8'hA5, 0);
    vecs[6]  = mkv(4'b0010, 8'h00, 8'h00, 8'h20, 8'h00, 0, 0, 8'h20, 8'h11, 0, 0, 8'h00, 8'hA5, 0);
    vecs[7]  = mkv(4'b0010, 8'h00, 8'h00, 8'h20, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'hA5, 0);
    vecs[8]  = mkv(4'b0010, 8'h00, 8'h00, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00, 0, 1, 8'h00, 8'h11, 0);
    vecs[9]  = mkv(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h11, 0);
    vecs[10] = mkv(4'b1100, 8'h10, 8'h3C, 8'h00, 8'h00, 0, 1, 8'h10, 8'h3C, 1, 0, 8'h00, 8'h11, 0);
    vecs[11] = mkv(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h10, 8'h3C, 0, 0, 8'h00, 8'h11, 0);
    vecs[12] = mkv(4'b1000, 8'h10, 8'h00, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h11, 1);
    vecs[13] = mkv(4'b1000, 8'h77, 8'h99, 8'h00, 8'h00, 0, 0, 8'h10, 8'h00, 1, 0, 8'h3C, 8'h11, 0);
    vecs[14] = mkv(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h10, 8'h00, 0, 0, 8'h3C, 8'h11, 0);

    step();
    step();
    check_out("reset_state", cur(), '0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      {req0_ler, req0_escreve, req1_ler, req1_escreve} = vecs[i].rq;
      req0_end = vecs[i].e0; req0_dado = vecs[i].d0;
      req1_end = vecs[i].e1; req1_dado = vecs[i].d1;
      step();
      check_out($sformatf("vec%0d", i), cur(), vecs[i].exp);
    end

    // Core writes continuously while port 1 holds a read: expect grants 0,0,0,0,1,0.
    req0_escreve = 1'b1; req0_end = 8'h40; req0_dado = 8'h55;
    req1_ler = 1'b1; req1_end = 8'h05; req1_dado = 8'h00;
    n_acks = 0; viol = 0; ordem = '0;
    for (int c = 0; c < 60 && n_acks < 6; c++) begin
      step();
      if (ack0 && ack1) viol++;
      if (mem_ler && mem_escreve) viol++;
      if (ack0) begin
        ordem[n_acks] = 1'b0;
        n_acks++;
      end else if (ack1) begin
        ordem[n_acks] = 1'b1;
        n_acks++;
        req1_ler = 1'b0;
        check_v("starve_read_data", 32'(dado_lido1), 32'h0000_00A5);
      end
    end
    req0_escreve = 1'b0;
    check_v("starve_ack_count", 32'(n_acks), 32'd6);
    check_v("starve_grant_order", 32'(ordem), 32'b01_0000);
    check_v("exclusive_ack_and_enable", 32'(viol), 32'd0);
    step();

    // Reset in the middle of a read aborts it at once.
    req1_ler = 1'b1; req1_end = 8'h05;
    step();
    check_v("rst_pre_mem_ler", 32'(mem_ler), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    req1_ler = 1'b0;
    check_out("rst_async_clear", cur(), '0);
    step();
    rst_n = 1'b1;
    step();
    check_out("rst_release_idle", cur(), '0);
    req0_escreve = 1'b1; req0_end = 8'h06; req0_dado = 8'h7E;
    step();
    check_v("rst_then_write_ack", 32'({mem_escreve, ack0, mem_end, mem_dado}), 32'h3_067E);
    req0_escreve = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
